// File: rtl/multi_bank_sram.sv
// rtl/multi_bank_sram.sv - NUM_SRAMS independent single-port read-first SRAM banks on flattened buses
module multi_bank_sram #(
    parameter int NUM_SRAMS  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRAMS-1:0]            en,
    input  logic [NUM_SRAMS-1:0]            we,
    input  logic [NUM_SRAMS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_SRAMS*DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar i = 0; i < NUM_SRAMS; i++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
        logic [ADDR_WIDTH-1:0] bank_addr;
        logic [DATA_WIDTH-1:0] bank_wdata;

        assign bank_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign bank_wdata = data_in[i*DATA_WIDTH +: DATA_WIDTH];

        // Storage carries no reset so it maps onto block RAM; reset only blocks the write.
        always_ff @(posedge clk) begin
            if (!rst && en[i] && we[i]) begin
                mem[bank_addr] <= bank_wdata;
            end
        end

        // Read-first: on a write cycle the lane captures the word being overwritten.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end else if (en[i]) begin
                data_out[i*DATA_WIDTH +: DATA_WIDTH] <= mem[bank_addr];
            end
        end
    end

endmodule

// File: tb/tb_multi_bank_sram.sv
// tb/tb_multi_bank_sram.sv - directed self-checking bench for multi_bank_sram
module tb_multi_bank_sram;

    localparam int NS = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic               clk;
    logic               rst;
    logic [NS-1:0]      en;
    logic [NS-1:0]      we;
    logic [NS*AW-1:0]   addr;
    logic [NS*DW-1:0]   data_in;
    logic [NS*DW-1:0]   data_out;

    int checks;
    int errors;

    multi_bank_sram #(
        .NUM_SRAMS (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        en      = '0;
        we      = '0;
        addr    = '0;
        data_in = '0;
    endtask

    task automatic set_lane(input int i, input logic e, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        en[i]              = e;
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        data_in[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input int i);
        return data_out[i*DW +: DW];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NS; i++) set_lane(i, 1'b1, 1'b1, 10'd9, 16'hDEAD);
        tick();
        tick();
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL reset_data_out: got %h expected %h", data_out, {NS*DW{1'b0}});
        end
        rst = 1'b0;
        idle();
        set_lane(0, 1'b1, 1'b0, 10'd9, 16'h0000);
        tick();
        checks++;
        if (lane(0) === 16'hDEAD) begin
            errors++;
            $display("FAIL reset_no_write: got %h expected anything but %h", lane(0), 16'hDEAD);
        end
        idle();
    endtask

    task automatic test_write_read();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_lane(0, 1'b1, 1'b1, 10'd5, 16'h1234);
        tick();
        set_lane(0, 1'b1, 1'b0, 10'd5, 16'h0000);
        tick();
        checks++;
        if (lane(0) !== 16'h1234) begin
            errors++;
            $display("FAIL wr_rd_bank0: got %h expected %h", lane(0), 16'h1234);
        end
        for (int i = 1; i < NS; i++) begin
            checks++;
            if (lane(i) !== 16'h0000) begin
                errors++;
                $display("FAIL wr_rd_idle_lane%0d: got %h expected %h", i, lane(i), 16'h0000);
            end
        end
        idle();
    endtask

    task automatic test_parallel();
        set_lane(0, 1'b1, 1'b1, 10'd3, 16'hAAAA);
        set_lane(1, 1'b1, 1'b1, 10'd3, 16'h5555);
        tick();
        set_lane(0, 1'b1, 1'b0, 10'd3, 16'h0000);
        set_lane(1, 1'b1, 1'b0, 10'd3, 16'h0000);
        tick();
        checks++;
        if (lane(0) !== 16'hAAAA) begin
            errors++;
            $display("FAIL par_bank0: got %h expected %h", lane(0), 16'hAAAA);
        end
        checks++;
        if (lane(1) !== 16'h5555) begin
            errors++;
            $display("FAIL par_bank1: got %h expected %h", lane(1), 16'h5555);
        end
        checks++;
        if (lane(2) !== 16'h0000 || lane(3) !== 16'h0000) begin
            errors++;
            $display("FAIL par_others: got %h_%h expected 0000_0000", lane(3), lane(2));
        end
        idle();
        // All four banks, same address, distinct data in one cycle.
        for (int i = 0; i < NS; i++) set_lane(i, 1'b1, 1'b1, 10'd100, 16'hC000 + 16'(i));
        tick();
        for (int i = 0; i < NS; i++) set_lane(i, 1'b1, 1'b0, 10'd100, 16'h0000);
        tick();
        checks++;
        if (data_out !== 64'hC003_C002_C001_C000) begin
            errors++;
            $display("FAIL par_all_banks: got %h expected %h", data_out, 64'hC003_C002_C001_C000);
        end
        idle();
    endtask

    task automatic test_read_first();
        set_lane(0, 1'b1, 1'b1, 10'd7, 16'h0011);
        tick();
        set_lane(0, 1'b1, 1'b1, 10'd7, 16'h0022);
        tick();
        checks++;
        if (lane(0) !== 16'h0011) begin
            errors++;
            $display("FAIL read_first_old: got %h expected %h", lane(0), 16'h0011);
        end
        set_lane(0, 1'b1, 1'b0, 10'd7, 16'h0000);
        tick();
        checks++;
        if (lane(0) !== 16'h0022) begin
            errors++;
            $display("FAIL read_first_new: got %h expected %h", lane(0), 16'h0022);
        end
        idle();
    endtask

    task automatic test_hold();
        set_lane(0, 1'b0, 1'b1, 10'd7, 16'hFFFF);
        set_lane(0, 1'b0, 1'b1, 10'd7, 16'hFFFF);
        tick();
        checks++;
        if (lane(0) !== 16'h0022) begin
            errors++;
            $display("FAIL hold_output: got %h expected %h", lane(0), 16'h0022);
        end
        set_lane(0, 1'b1, 1'b0, 10'd7, 16'h0000);
        tick();
        checks++;
        if (lane(0) !== 16'h0022) begin
            errors++;
            $display("FAIL hold_no_write: got %h expected %h", lane(0), 16'h0022);
        end
        // Reset during a write cancels it; the next read sees the prior contents.
        rst = 1'b1;
        set_lane(0, 1'b1, 1'b1, 10'd7, 16'hBEEF);
        tick();
        checks++;
        if (lane(0) !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_clear: got %h expected %h", lane(0), 16'h0000);
        end
        rst = 1'b0;
        set_lane(0, 1'b1, 1'b0, 10'd7, 16'h0000);
        tick();
        checks++;
        if (lane(0) !== 16'h0022) begin
            errors++;
            $display("FAIL midrst_no_write: got %h expected %h", lane(0), 16'h0022);
        end
        idle();
    endtask

    task automatic test_boundaries();
        set_lane(NS-1, 1'b1, 1'b1, 10'd0, 16'h0F0F);
        tick();
        set_lane(NS-1, 1'b1, 1'b1, 10'd1023, 16'hF0F0);
        tick();
        set_lane(NS-1, 1'b1, 1'b0, 10'd0, 16'h0000);
        tick();
        checks++;
        if (lane(NS-1) !== 16'h0F0F) begin
            errors++;
            $display("FAIL bound_addr0: got %h expected %h", lane(NS-1), 16'h0F0F);
        end
        set_lane(NS-1, 1'b1, 1'b0, 10'd1023, 16'h0000);
        tick();
        checks++;
        if (lane(NS-1) !== 16'hF0F0) begin
            errors++;
            $display("FAIL bound_addr_max: got %h expected %h", lane(NS-1), 16'hF0F0);
        end
        checks++;
        if (lane(0) !== 16'h0022) begin
            errors++;
            $display("FAIL bound_bank0_held: got %h expected %h", lane(0), 16'h0022);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_parallel();
        test_read_first();
        test_hold();
        test_boundaries();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
